rx_fifo_buff: RTL and testbench
===============================

// Module: rx_fifo_buff
// PURPOSE
//   Single-clock synchronous FIFO that buffers MAC receive bytes until the transmit controller drains them.
//   Two instances sit in the Ethernet bridge, both clocked by rx_mac_clk:
//     - 8-bit data FIFO for frame bytes.
//     - 16-bit FIFO (WIDTH=16) for frame lengths, written on rx_stat_valid.
//   Provides a registered read port with a one-cycle data-valid strobe, plus full/empty flags for flow control.
// PARAMETERS
//   WIDTH   8   data word width in bits
//   ADDR_W  11  address bits; DEPTH = 2**ADDR_W words (2048 holds one max-size frame plus margin)
// PORTS
//   clk            in   1      single clock; every register updates on its rising edge
//   rst_n          in   1      asynchronous reset, active low
//   write          in   1      write request; data_in is stored when write=1 and full=0
//   data_in        in   WIDTH  write data
//   read           in   1      read request; a word is popped when read=1 and empty=0
//   rx_mac_last    in   1      marks data_in as the last byte of a frame (qualified by write)
//   data_out       out  WIDTH  registered read data
//   tx_valid_flag  out  1      1 for exactly one cycle when data_out has just been updated by a pop
//   empty          out  1      count==0
//   full           out  1      count==DEPTH
// BEHAVIOUR
//   - Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
//   - While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, data_out=0, tx_valid_flag=0, empty=1, full=0. Memory contents are not cleared.
//   - wr_en = write & ~full. On wr_en: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
//   - rd_en = read & ~empty. On rd_en: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1; tx_valid_flag <= 1.
//   - When rd_en=0: tx_valid_flag <= 0 and data_out holds its previous value.
//   - Read latency: data_out and tx_valid_flag are valid on the cycle after read is sampled.
//   - Pointers are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
//   - count is ADDR_W+1 bits wide:
//       wr_en only: +1.  rd_en only: -1.  Both or neither: unchanged.
//   - empty and full are driven combinationally from count.
//   - Write while full is ignored: no pointer or count change, no error flag.
//   - Read while empty is ignored: tx_valid_flag=0 and data_out is unchanged.
//   - Simultaneous read+write:
//       Empty FIFO: only the write takes effect; the written word is readable on the next cycle (no fall-through).
//       Full FIFO: only the read takes effect; the write is dropped, because full is evaluated before the pop.
//       Otherwise: both take effect.
//   - Reset asserted mid-operation: state returns to the reset values immediately; any in-flight frame is discarded.
//   - rx_mac_last is used only by the optional feature below.
// CONFIGURATION
//   RX_FIFO_LAST_TAG_EN
//     Defined:
//       - rx_mac_last is stored as an extra bit alongside each word.
//       - Extra output data_last (1 bit) is registered with data_out and reset to 0.
//       - Extra output frame_cnt (ADDR_W+1 bits) counts stored words whose last bit is set:
//           +1 when a word with last=1 is written; -1 when such a word is popped; reset to 0.
//     Undefined: rx_mac_last is ignored; data_last and frame_cnt do not exist.
// STRUCTURE
//   - Shared package (bridge_pkg): default widths FIFO_WIDTH=8, FIFO_ADDR_W=11, LEN_WIDTH=16.
//   - One sub-module, rx_fifo_ram: simple dual-port memory of DEPTH x (WIDTH[+1]) words.
//       Synchronous write port; synchronous read port whose output register forms data_out.
//   - Pointer and count logic stays in rx_fifo_buff.
// TESTING
//   1. Reset: hold rst_n=0 for 3 cycles, then release -> empty=1, full=0, tx_valid_flag=0, data_out=0.
//   2. Ordering: write 0x11, 0x22, 0x33, then assert read for 3 cycles.
//      -> data_out = 0x11, 0x22, 0x33 on consecutive cycles, tx_valid_flag=1 on each; empty=1 afterwards.
//   3. Full: write DEPTH words (value = index) -> full=1 after the 2048th write.
//      A 2049th write is dropped; reading 2048 words returns 0..0xFF repeating with no extra word.
//   4. Simultaneous read+write: when empty -> count becomes 1 and tx_valid_flag=0.
//      When holding 5 words -> count stays 5 and data_out is the oldest word.
//   5. WIDTH=16 instance: write 0x05EA, read -> data_out=0x05EA with tx_valid_flag pulsed for 1 cycle.
//   6. RX_FIFO_LAST_TAG_EN defined: write 4 bytes with rx_mac_last=1 on the 4th -> frame_cnt=1.
//      Pop all 4 -> data_last=1 with the 4th byte, then frame_cnt=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared widths for the Ethernet bridge receive path.
// rx_fifo_buff optionally stores a per-word frame-end tag when RX_FIFO_LAST_TAG_EN is defined.
package bridge_pkg;

  localparam int unsigned FIFO_WIDTH  = 8;
  localparam int unsigned FIFO_ADDR_W = 11;
  localparam int unsigned LEN_WIDTH   = 16;

endpackage : bridge_pkg

// File: rtl/rx_fifo_buff_if.sv
// Handshake bundle between a producer/consumer (master) and rx_fifo_buff (slave).
// RX_FIFO_LAST_TAG_EN adds the data_last and frame_cnt outputs.
interface rx_fifo_buff_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 11
);

  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic             rx_mac_last;
  logic [WIDTH-1:0] data_out;
  logic             tx_valid_flag;
  logic             empty;
  logic             full;

`ifdef RX_FIFO_LAST_TAG_EN
  logic             data_last;
  logic [ADDR_W:0]  frame_cnt;

  modport master (
    output write, data_in, read, rx_mac_last,
    input  data_out, tx_valid_flag, empty, full, data_last, frame_cnt
  );

  modport slave (
    input  write, data_in, read, rx_mac_last,
    output data_out, tx_valid_flag, empty, full, data_last, frame_cnt
  );
`else
  modport master (
    output write, data_in, read, rx_mac_last,
    input  data_out, tx_valid_flag, empty, full
  );

  modport slave (
    input  write, data_in, read, rx_mac_last,
    output data_out, tx_valid_flag, empty, full
  );
`endif

endinterface : rx_fifo_buff_if

// File: rtl/rx_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read into a reset output register.
module rx_fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [Depth];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is intentionally left uninitialised so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule : rx_fifo_ram

// File: rtl/rx_fifo_buff.sv
// Single-clock receive FIFO with registered read port and one-cycle valid strobe.
// Define RX_FIFO_LAST_TAG_EN to store rx_mac_last per word and expose data_last/frame_cnt.
module rx_fifo_buff
  import bridge_pkg::*;
#(
  parameter int unsigned WIDTH  = FIFO_WIDTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input logic          clk,
  input logic          rst_n,
  rx_fifo_buff_if.slave bus
);

`ifdef RX_FIFO_LAST_TAG_EN
  localparam int unsigned RamW = WIDTH + 1;
`else
  localparam int unsigned RamW = WIDTH;
`endif

  localparam logic [ADDR_W:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q;
  logic              wr_en, rd_en;
  logic [RamW-1:0]   wr_word, rd_word;

  // Flags come from the registered count, so a write into a full FIFO is dropped even when
  // a pop happens in the same cycle.
  assign bus.empty = (count_q == '0);
  assign bus.full  = (count_q == FullCnt);
  assign wr_en     = bus.write & ~bus.full;
  assign rd_en     = bus.read & ~bus.empty;

`ifdef RX_FIFO_LAST_TAG_EN
  assign wr_word = {bus.rx_mac_last, bus.data_in};
`else
  assign wr_word = bus.data_in;
`endif

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      valid_q <= rd_en;
    end
  end

  rx_fifo_ram #(
    .WIDTH  (RamW),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  assign bus.data_out      = rd_word[WIDTH-1:0];
  assign bus.tx_valid_flag = valid_q;

`ifdef RX_FIFO_LAST_TAG_EN
  logic [ADDR_W:0] frame_cnt_q, frame_cnt_d;
  logic            last_in, last_out;

  // The tag of a popped word is only visible once it reaches the read register, so the
  // decrement lands on the cycle its data_last is presented.
  assign last_in  = wr_en & bus.rx_mac_last;
  assign last_out = valid_q & rd_word[WIDTH];

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (last_in && !last_out) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else if (!last_in && last_out) begin
      frame_cnt_d = frame_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.data_last = rd_word[WIDTH];
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule : rx_fifo_buff

// File: tb/tb_rx_fifo_buff.sv
// Directed bench for rx_fifo_buff: 8-bit and 16-bit instances, optional last-tag checks.
module tb_rx_fifo_buff;

  localparam int unsigned AddrW = 11;
  localparam int unsigned Depth = 2 ** AddrW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_fifo_buff_if #(.WIDTH(8),  .ADDR_W(AddrW)) bus8  ();
  rx_fifo_buff_if #(.WIDTH(16), .ADDR_W(AddrW)) bus16 ();

  rx_fifo_buff #(.WIDTH(8), .ADDR_W(AddrW)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  rx_fifo_buff #(.WIDTH(16), .ADDR_W(AddrW)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [7:0] dout;
    logic       vld;
    logic       emp;
    logic       ful;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic wr, input logic [7:0] din, input logic rd, input logic last);
    bus8.write       = wr;
    bus8.data_in     = din;
    bus8.read        = rd;
    bus8.rx_mac_last = last;
  endtask

  initial begin
    drive8(1'b0, 8'h00, 1'b0, 1'b0);
    bus16.write = 1'b0; bus16.data_in = '0; bus16.read = 1'b0; bus16.rx_mac_last = 1'b0;

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_empty", 32'(bus8.empty), 32'd1);
    check("rst_full", 32'(bus8.full), 32'd0);
    check("rst_valid", 32'(bus8.tx_valid_flag), 32'd0);
    check("rst_dout", 32'(bus8.data_out), 32'd0);
    check("rst16_empty", 32'(bus16.empty), 32'd1);

    // Ordering, empty-read, simultaneous read+write on empty and on 5 words
    //                wr   din    rd   dout   vld  emp  ful
    vecs.push_back('{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h44, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b1, 8'(8'h51 + i), 1'b0, 8'h44, 1'b0, 1'b0, 1'b0});
    end
    vecs.push_back('{1'b1, 8'h56, 1'b1, 8'h51, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b0, 8'h00, 1'b1, 8'(8'h52 + i), 1'b1, (i == 4), 1'b0});
    end
    vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h56, 1'b0, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      drive8(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
      step();
      check($sformatf("vec%0d_dout", i), 32'(bus8.data_out), 32'(vecs[i].dout));
      check($sformatf("vec%0d_valid", i), 32'(bus8.tx_valid_flag), 32'(vecs[i].vld));
      check($sformatf("vec%0d_empty", i), 32'(bus8.empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d_full", i), 32'(bus8.full), 32'(vecs[i].ful));
    end
    drive8(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to DEPTH, drop overflow, full read+write, drain
    for (int i = 0; i < Depth; i++) begin
      drive8(1'b1, 8'(i), 1'b0, 1'b0);
      step();
      if (i == Depth - 2) check("full_early", 32'(bus8.full), 32'd0);
    end
    check("full_set", 32'(bus8.full), 32'd1);
    drive8(1'b1, 8'hEE, 1'b0, 1'b0);
    step();
    check("full_drop", 32'(bus8.full), 32'd1);
    drive8(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    check("full_rw_dout", 32'(bus8.data_out), 32'd0);
    check("full_rw_full", 32'(bus8.full), 32'd0);
    for (int i = 1; i < Depth; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check($sformatf("drain%0d", i), 32'(bus8.data_out), 32'(i[7:0]));
    end
    check("drain_empty", 32'(bus8.empty), 32'd1);
    step();
    check("drain_extra_valid", 32'(bus8.tx_valid_flag), 32'd0);
    check("drain_extra_dout", 32'(bus8.data_out), 32'hFF);
    drive8(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame
    drive8(1'b1, 8'hAA, 1'b0, 1'b0); step();
    drive8(1'b1, 8'hBB, 1'b0, 1'b0); step();
    drive8(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("mid_pre_dout", 32'(bus8.data_out), 32'hAA);
    drive8(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_empty", 32'(bus8.empty), 32'd1);
    check("mid_rst_dout", 32'(bus8.data_out), 32'd0);
    check("mid_rst_valid", 32'(bus8.tx_valid_flag), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    drive8(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("mid_rst_discard", 32'(bus8.tx_valid_flag), 32'd0);
    drive8(1'b0, 8'h00, 1'b0, 1'b0);

    // 16-bit length FIFO
    bus16.write = 1'b1; bus16.data_in = 16'h05EA; step();
    bus16.write = 1'b0; bus16.read = 1'b1; step();
    check("w16_dout", 32'(bus16.data_out), 32'h05EA);
    check("w16_valid", 32'(bus16.tx_valid_flag), 32'd1);
    bus16.read = 1'b0; step();
    check("w16_valid_drop", 32'(bus16.tx_valid_flag), 32'd0);
    check("w16_hold", 32'(bus16.data_out), 32'h05EA);

`ifdef RX_FIFO_LAST_TAG_EN
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, 8'(8'hA0 + i), 1'b0, (i == 3));
      step();
    end
    drive8(1'b0, 8'h00, 1'b0, 1'b0);
    check("tag_frame_cnt1", 32'(bus8.frame_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      check($sformatf("tag_dout%0d", i), 32'(bus8.data_out), 32'(8'hA0 + i));
      check($sformatf("tag_last%0d", i), 32'(bus8.data_last), 32'(i == 3));
    end
    drive8(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("tag_frame_cnt0", 32'(bus8.frame_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rx_fifo_buff
